// File: rtl/adma2_descriptor_sequencer.sv
// ADMA2 descriptor sequencer: walks the descriptor table, issues transfer
// segments to the data mover and raises host-visible status flags.
module adma2_descriptor_sequencer #(
   parameter int unsigned DESC_BYTES    = 12,
   parameter int unsigned FETCH_TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        start,
   input  logic [63:0] Initial_ADMA_System_Address,
   output logic        desc_req,
   output logic [63:0] desc_addr,
   input  logic        desc_ack,
   input  logic [95:0] desc_data,
   output logic        xfer_start,
   output logic [63:0] xfer_addr,
   output logic [16:0] xfer_len,
   input  logic        xfer_done,
   input  logic        xfer_error,
   output logic [63:0] ADMA_System_Address_Register,
   output logic [1:0]  ADMA_Error_State,
   output logic        busy,
   output logic        DMA_Interrupt,
   output logic        ADMA_Error,
   output logic        Transfer_complete,
   input  logic        ack_DMA_Interrupt,
   input  logic        ack_ADMA_Error,
   input  logic        ack_Transfer_complete
);

   // Encodings double as the ADMA_Error_State report values.
   typedef enum logic [1:0] {
      ST_STOP = 2'b00,
      ST_FDS  = 2'b01,
      ST_CADR = 2'b10,
      ST_TFR  = 2'b11
   } state_t;

   localparam logic [63:0] STEP    = 64'(DESC_BYTES);
   localparam logic [7:0]  TMO_MAX = 8'(FETCH_TIMEOUT - 1);

   state_t      state;
   logic [63:0] addr;
   logic [7:0]  tmo;
   logic        d_valid;
   logic        d_end;
   logic        d_int;
   logic [1:0]  d_act;
   logic [63:0] d_addr;

   logic unused;
   assign unused = ^{desc_data[15:6], desc_data[3]};

   assign desc_addr                    = addr;
   assign ADMA_System_Address_Register = addr;
   assign busy                         = (state != ST_STOP);

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state             <= ST_STOP;
         addr              <= '0;
         tmo               <= '0;
         d_valid           <= 1'b0;
         d_end             <= 1'b0;
         d_int             <= 1'b0;
         d_act             <= 2'b00;
         d_addr            <= '0;
         desc_req          <= 1'b0;
         xfer_start        <= 1'b0;
         xfer_addr         <= '0;
         xfer_len          <= '0;
         ADMA_Error_State  <= 2'b00;
         DMA_Interrupt     <= 1'b0;
         ADMA_Error        <= 1'b0;
         Transfer_complete <= 1'b0;
      end else begin
         xfer_start <= 1'b0;
         // Clears first; any set later in this block overrides them.
         if (ack_DMA_Interrupt)
            DMA_Interrupt <= 1'b0;
         if (ack_Transfer_complete)
            Transfer_complete <= 1'b0;
         if (ack_ADMA_Error) begin
            ADMA_Error       <= 1'b0;
            ADMA_Error_State <= 2'b00;
         end

         unique case (state)
            ST_STOP: begin
               if (start && !ADMA_Error) begin
                  addr     <= Initial_ADMA_System_Address;
                  tmo      <= '0;
                  desc_req <= 1'b1;
                  state    <= ST_FDS;
               end
            end

            ST_FDS: begin
               if (desc_ack) begin
                  desc_req  <= 1'b0;
                  d_valid   <= desc_data[0];
                  d_end     <= desc_data[1];
                  d_int     <= desc_data[2];
                  d_act     <= desc_data[5:4];
                  d_addr    <= desc_data[95:32];
                  xfer_addr <= desc_data[95:32];
                  xfer_len  <= {desc_data[31:16] == 16'd0,
                                desc_data[31:16]};
                  // Issued here so it is seen during ST_CADR.
                  xfer_start <= desc_data[0] &&
                                (desc_data[5:4] == 2'b10);
                  state     <= ST_CADR;
               end else if (tmo == TMO_MAX) begin
                  desc_req         <= 1'b0;
                  ADMA_Error       <= 1'b1;
                  ADMA_Error_State <= ST_FDS;
                  state            <= ST_STOP;
               end else begin
                  tmo <= tmo + 8'd1;
               end
            end

            ST_CADR: begin
               if (!d_valid) begin
                  ADMA_Error       <= 1'b1;
                  ADMA_Error_State <= ST_FDS;
                  state            <= ST_STOP;
               end else if (d_act == 2'b10) begin
                  state <= ST_TFR;
               end else begin
                  if (d_int)
                     DMA_Interrupt <= 1'b1;
                  if (d_end) begin
                     Transfer_complete <= 1'b1;
                     state             <= ST_STOP;
                  end else begin
                     tmo      <= '0;
                     desc_req <= 1'b1;
                     state    <= ST_FDS;
                  end
                  if (d_act == 2'b11) begin
                     if (!d_end)
                        addr <= d_addr;
                  end else begin
                     addr <= addr + STEP;
                  end
               end
            end

            ST_TFR: begin
               if (xfer_error) begin
                  ADMA_Error       <= 1'b1;
                  ADMA_Error_State <= ST_TFR;
                  state            <= ST_STOP;
               end else if (xfer_done) begin
                  addr <= addr + STEP;
                  if (d_int)
                     DMA_Interrupt <= 1'b1;
                  if (d_end) begin
                     Transfer_complete <= 1'b1;
                     state             <= ST_STOP;
                  end else begin
                     tmo      <= '0;
                     desc_req <= 1'b1;
                     state    <= ST_FDS;
                  end
               end
            end

            default: state <= ST_STOP;
         endcase
      end
   end

endmodule

// File: tb/tb_adma2_descriptor_sequencer.sv
// Scoreboard bench for adma2_descriptor_sequencer: expected fetch addresses
// and segment commands are queued by the stimulus and checked by a monitor.
module tb_adma2_descriptor_sequencer;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        start = 1'b0;
   logic [63:0] init_addr = '0;
   logic        desc_req;
   logic [63:0] desc_addr;
   logic        desc_ack = 1'b0;
   logic [95:0] desc_data = '0;
   logic        xfer_start;
   logic [63:0] xfer_addr;
   logic [16:0] xfer_len;
   logic        xfer_done = 1'b0;
   logic        xfer_error = 1'b0;
   logic [63:0] sys_addr;
   logic [1:0]  err_state;
   logic        busy;
   logic        dma_int;
   logic        adma_err;
   logic        tc;
   logic        ack_int = 1'b0;
   logic        ack_err = 1'b0;
   logic        ack_tc = 1'b0;

   int checks = 0;
   int failures = 0;

   typedef struct {
      logic [63:0] a;
      logic [16:0] l;
   } xfer_t;

   xfer_t       exp_x[$];
   logic [63:0] exp_d[$];

   always #5 clk = ~clk;

   adma2_descriptor_sequencer dut (
      .clk                          (clk),
      .reset_n                      (reset_n),
      .start                        (start),
      .Initial_ADMA_System_Address  (init_addr),
      .desc_req                     (desc_req),
      .desc_addr                    (desc_addr),
      .desc_ack                     (desc_ack),
      .desc_data                    (desc_data),
      .xfer_start                   (xfer_start),
      .xfer_addr                    (xfer_addr),
      .xfer_len                     (xfer_len),
      .xfer_done                    (xfer_done),
      .xfer_error                   (xfer_error),
      .ADMA_System_Address_Register (sys_addr),
      .ADMA_Error_State             (err_state),
      .busy                         (busy),
      .DMA_Interrupt                (dma_int),
      .ADMA_Error                   (adma_err),
      .Transfer_complete            (tc),
      .ack_DMA_Interrupt            (ack_int),
      .ack_ADMA_Error               (ack_err),
      .ack_Transfer_complete        (ack_tc)
   );

   task automatic chk(input string name, input logic [63:0] act,
                      input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [95:0] mk(input bit v, input bit e,
                                      input bit i, input logic [1:0] act,
                                      input logic [15:0] len,
                                      input logic [63:0] a);
      return {a, len, 10'd0, act, 1'b0, i, e, v};
   endfunction

   // Monitor: compares every fetch and every segment command to the queues.
   logic prev_req = 1'b0;
   always @(negedge clk) begin
      if (desc_req && !prev_req) begin
         if (exp_d.size() == 0) begin
            chk("unexpected_fetch", desc_addr, 64'hx);
         end else begin
            chk("desc_addr", desc_addr, exp_d.pop_front());
         end
      end
      prev_req <= desc_req;
      if (xfer_start) begin
         if (exp_x.size() == 0) begin
            chk("unexpected_xfer_start", xfer_addr, 64'hx);
         end else begin
            xfer_t x;
            x = exp_x.pop_front();
            chk("xfer_addr", xfer_addr, x.a);
            chk("xfer_len", 64'(xfer_len), 64'(x.l));
         end
      end
   end

   task automatic step();
      @(negedge clk);
   endtask

   task automatic go(input logic [63:0] a);
      init_addr = a;
      start = 1'b1;
      step();
      start = 1'b0;
   endtask

   task automatic fetch(input logic [95:0] d);
      for (int i = 0; i < 20 && !desc_req; i++)
         step();
      if (!desc_req) begin
         chk("fetch_wait", 64'(desc_req), 64'd1);
      end else begin
         desc_data = d;
         desc_ack = 1'b1;
         step();
         desc_ack = 1'b0;
      end
   endtask

   task automatic done(input bit err, input bit dn);
      xfer_error = err;
      xfer_done = dn;
      step();
      xfer_error = 1'b0;
      xfer_done = 1'b0;
   endtask

   task automatic ack_all();
      ack_int = 1'b1;
      ack_err = 1'b1;
      ack_tc = 1'b1;
      step();
      ack_int = 1'b0;
      ack_err = 1'b0;
      ack_tc = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      repeat (3) step();
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_req", 64'(desc_req), 64'd0);
      chk("rst_addr", sys_addr, 64'd0);
      chk("rst_flags", 64'({dma_int, adma_err, tc, err_state}), 64'd0);
      reset_n = 1'b1;
      step();

      // 1: single tran, End=1
      exp_d.push_back(64'h1000);
      exp_x.push_back('{64'h8000, 17'd512});
      go(64'h1000);
      fetch(mk(1, 1, 0, 2'b10, 16'h0200, 64'h8000));
      step();
      step();
      done(0, 1);
      chk("t1_tc", 64'(tc), 64'd1);
      chk("t1_addr", sys_addr, 64'h100C);
      chk("t1_busy", 64'(busy), 64'd0);
      chk("t1_int", 64'(dma_int), 64'd0);
      ack_all();
      chk("t1_tc_clr", 64'(tc), 64'd0);

      // 2: Length=0 means 64 KiB
      exp_d.push_back(64'h3000);
      exp_x.push_back('{64'h9000, 17'h10000});
      go(64'h3000);
      fetch(mk(1, 1, 0, 2'b10, 16'h0000, 64'h9000));
      step();
      done(0, 1);
      chk("t2_tc", 64'(tc), 64'd1);
      chk("t2_addr", sys_addr, 64'h300C);
      ack_all();

      // 3: link then tran with Int
      exp_d.push_back(64'h1000);
      exp_d.push_back(64'h2000);
      exp_x.push_back('{64'hA000, 17'd16});
      go(64'h1000);
      fetch(mk(1, 0, 0, 2'b11, 16'h0000, 64'h2000));
      fetch(mk(1, 1, 1, 2'b10, 16'h0010, 64'hA000));
      step();
      done(0, 1);
      chk("t3_int", 64'(dma_int), 64'd1);
      chk("t3_tc", 64'(tc), 64'd1);
      chk("t3_addr", sys_addr, 64'h200C);
      ack_all();

      // 4: invalid descriptor, start blocked until error ack
      exp_d.push_back(64'h4000);
      go(64'h4000);
      fetch(mk(0, 0, 0, 2'b10, 16'h0040, 64'hC000));
      step();
      chk("t4_err", 64'(adma_err), 64'd1);
      chk("t4_state", 64'(err_state), 64'd1);
      chk("t4_addr", sys_addr, 64'h4000);
      go(64'h5000);
      step();
      chk("t4_blocked", 64'({busy, desc_req}), 64'd0);
      ack_err = 1'b1;
      step();
      ack_err = 1'b0;
      chk("t4_err_clr", 64'({adma_err, err_state}), 64'd0);
      exp_d.push_back(64'h5000);
      go(64'h5000);
      fetch(mk(1, 1, 1, 2'b00, 16'h0000, 64'h0));
      step();
      chk("t4_nop_flags", 64'({dma_int, tc, busy}), 64'b110);
      chk("t4_nop_addr", sys_addr, 64'h500C);
      ack_all();

      // 5a: fetch timeout
      exp_d.push_back(64'h6000);
      go(64'h6000);
      n = 0;
      for (int i = 0; i < 400 && !adma_err; i++) begin
         if (desc_req)
            n++;
         step();
      end
      chk("t5_tmo_err", 64'(adma_err), 64'd1);
      chk("t5_tmo_cycles", 64'(n), 64'd255);
      chk("t5_tmo_state", 64'(err_state), 64'd1);
      chk("t5_tmo_idle", 64'({busy, desc_req}), 64'd0);
      ack_all();

      // 5b: segment error beats same-cycle done
      exp_d.push_back(64'h7000);
      exp_x.push_back('{64'hB000, 17'd64});
      go(64'h7000);
      fetch(mk(1, 0, 1, 2'b10, 16'h0040, 64'hB000));
      step();
      done(1, 1);
      chk("t5_xerr", 64'({adma_err, err_state}), 64'b111);
      chk("t5_xerr_addr", sys_addr, 64'h7000);
      chk("t5_xerr_misc", 64'({busy, tc, dma_int}), 64'd0);
      ack_all();

      // 6: acks held high -> one-cycle flags
      ack_int = 1'b1;
      ack_err = 1'b1;
      ack_tc = 1'b1;
      exp_d.push_back(64'h1000);
      exp_x.push_back('{64'h8000, 17'd512});
      go(64'h1000);
      fetch(mk(1, 1, 1, 2'b10, 16'h0200, 64'h8000));
      step();
      done(0, 1);
      chk("t6_set", 64'({dma_int, tc}), 64'b11);
      step();
      chk("t6_gone", 64'({dma_int, tc}), 64'b00);
      exp_d.push_back(64'h4000);
      go(64'h4000);
      fetch(mk(0, 0, 0, 2'b00, 16'h0, 64'h0));
      step();
      chk("t6_err_set", 64'({adma_err, err_state}), 64'b101);
      step();
      chk("t6_err_gone", 64'({adma_err, err_state}), 64'b000);
      ack_int = 1'b0;
      ack_err = 1'b0;
      ack_tc = 1'b0;

      // 6b: reset during segment
      exp_d.push_back(64'h1000);
      exp_x.push_back('{64'h8000, 17'd512});
      go(64'h1000);
      fetch(mk(1, 1, 1, 2'b10, 16'h0200, 64'h8000));
      step();
      reset_n = 1'b0;
      step();
      chk("t6_rst_ctl", 64'({busy, desc_req, xfer_start, dma_int,
                             adma_err, tc, err_state}), 64'd0);
      chk("t6_rst_addr", sys_addr, 64'd0);
      chk("t6_rst_xaddr", xfer_addr, 64'd0);
      chk("t6_rst_xlen", 64'(xfer_len), 64'd0);
      reset_n = 1'b1;
      done(0, 1);
      step();
      chk("t6_post_rst", 64'({tc, dma_int, busy}), 64'd0);

      chk("fetch_queue_empty", 64'(exp_d.size()), 64'd0);
      chk("xfer_queue_empty", 64'(exp_x.size()), 64'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
